scan_mux: RTL



---
 rtl/scan_mux_pkg.sv | 23 ++
 rtl/scan_mux_rr_next_ch.sv | 39 +++
 rtl/scan_mux.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/scan_mux_pkg.sv
// Shared definitions for scan_mux: FSM state encoding, mode constants and the
// index-width helper used to validate SEL_W.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = ((1 << i) < value) ? i + 1 : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_mux_rr_next_ch.sv
// rr_next_ch: finds the next set mask bit strictly after cur (cyclic), flagging
// an empty mask and a search that wrapped to a lower-or-equal index.
module rr_next_ch #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] cur_i,
    input  logic [N_CH-1:0]  mask_i,
    output logic [SEL_W-1:0] next_o,
    output logic             none_o,
    output logic             wrapped_o
);

    logic [SEL_W-1:0] after_idx;
    logic [SEL_W-1:0] low_idx;
    logic             after_hit;
    logic             any_hit;
    logic             above;

    // Descending walk: the last hit kept is the lowest index above cur / overall.
    always_comb begin
        after_idx = '0;
        low_idx   = '0;
        after_hit = 1'b0;
        any_hit   = 1'b0;
        above     = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            above     = mask_i[k] && (k > int'(cur_i));
            low_idx   = mask_i[k] ? SEL_W'(k) : low_idx;
            any_hit   = any_hit | mask_i[k];
            after_idx = above ? SEL_W'(k) : after_idx;
            after_hit = after_hit | above;
        end
        next_o    = after_hit ? after_idx : low_idx;
        none_o    = !any_hit;
        wrapped_o = any_hit && !after_hit;
    end

endmodule

// File: rtl/scan_mux.sv
// scan_mux: N_CH-channel, W-bit time-division multiplexer with manual select,
// auto-scan with per-channel skip mask, dwell timing and wrap strobe.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 1,
    parameter int SEL_W = 2,
    parameter int DWELL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic [N_CH*W-1:0] din,
    output logic [W-1:0]      dout,
    output logic [SEL_W-1:0]  ch_out,
    output logic              valid,
    output logic              wrap
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    if (SEL_W != clog2(N_CH)) begin : g_sel_w_check
        $error("scan_mux: SEL_W must equal clog2(N_CH)");
    end

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [W-1:0]     dout_q, dout_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [SEL_W-1:0] nx_ch_s;
    logic             nx_none_s;
    logic             nx_wrap_s;
    logic             sel_ok_s;
    logic             cur_in_mask_s;
    logic             scanning_s;

    function automatic logic [W-1:0] pick(input logic [SEL_W-1:0] idx,
                                          input logic [N_CH*W-1:0] bus);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++) begin
            r = (int'(idx) == k) ? bus[k*W +: W] : r;
        end
        return r;
    endfunction

    rr_next_ch #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_next_ch (
        .cur_i     (ch_q),
        .mask_i    (ch_mask),
        .next_o    (nx_ch_s),
        .none_o    (nx_none_s),
        .wrapped_o (nx_wrap_s)
    );

    assign sel_ok_s      = int'(sel_in) < N_CH;
    assign cur_in_mask_s = ch_mask[ch_q];
    // Counter only advances while a channel was actually presented in SCAN last cycle,
    // so a resume from IDLE re-presents the frozen count.
    assign scanning_s    = (state_q == ST_SCAN) && valid_q;

    // Next-state and next-output logic; the action taken is that of the state being entered.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (mode)
                MODE_MANUAL: state_d = ST_MANUAL;
                MODE_SCAN:   state_d = ST_SCAN;
                default:     state_d = ST_IDLE;
            endcase
        end
        case (state_d)
            ST_MANUAL: begin
                cnt_d = 8'd0;
                if (sel_ok_s) begin
                    ch_d    = sel_in;
                    dout_d  = pick(sel_in, din);
                    valid_d = 1'b1;
                end else begin
                    dout_d = '0;
                end
            end
            ST_SCAN: begin
                if (nx_none_s) begin
                    dout_d = '0;
                    cnt_d  = 8'd0;
                end else if (!cur_in_mask_s || (scanning_s && (cnt_q == DWELL_LAST))) begin
                    ch_d    = nx_ch_s;
                    cnt_d   = 8'd0;
                    dout_d  = pick(nx_ch_s, din);
                    valid_d = 1'b1;
                    wrap_d  = nx_wrap_s;
                end else begin
                    cnt_d   = scanning_s ? cnt_q + 8'd1 : cnt_q;
                    dout_d  = pick(ch_q, din);
                    valid_d = 1'b1;
                end
            end
            default: begin
                ch_d = ch_q;
            end
        endcase
    end

    // State, dwell counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            dout_q  <= '0;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign dout   = dout_q;
    assign ch_out = ch_q;
    assign valid  = valid_q;
    assign wrap   = wrap_q;

endmodule
